// File: rtl/piso_serializer.sv
// Parallel-in, serial-out serializer with valid/ready load handshake and done pulse.
// Optional even-parity bit appended after the data bits when PISO_PARITY_EN is defined.
module piso_serializer #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             clear_n,
  input  logic [WIDTH-1:0] din,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             so,
  output logic             so_valid,
  output logic             busy,
  output logic             done
);

`ifdef PISO_PARITY_EN
  localparam int FRAME_LEN = WIDTH + 1;
`else
  localparam int FRAME_LEN = WIDTH;
`endif
  localparam int CW = $clog2(FRAME_LEN + 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_reg, state_next;
  logic [CW-1:0]    cnt_reg, cnt_next;
  logic [WIDTH-1:0] sr_reg, sr_next;
  logic             so_reg, so_next;
  logic             so_valid_reg, so_valid_next;
  logic             done_reg, done_next;
`ifdef PISO_PARITY_EN
  logic             par_reg, par_next;
`endif

  // Reorder the word so the first bit to send always sits at the top index.
  logic [WIDTH-1:0] ord;
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_ord
      if (MSB_FIRST) begin : g_msb
        assign ord[gi] = din[gi];
      end else begin : g_lsb
        assign ord[gi] = din[WIDTH-1-gi];
      end
    end
  endgenerate

  logic last_bit;
  logic accept;

  assign last_bit   = (state_reg == SHIFT) && (cnt_reg == CW'(FRAME_LEN - 1));
  assign load_ready = (state_reg == IDLE) || last_bit;
  assign accept     = load_valid && load_ready;

  always_ff @(posedge clk) begin
    if (!clear_n) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      sr_reg       <= '0;
      so_reg       <= 1'b0;
      so_valid_reg <= 1'b0;
      done_reg     <= 1'b0;
`ifdef PISO_PARITY_EN
      par_reg      <= 1'b0;
`endif
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      sr_reg       <= sr_next;
      so_reg       <= so_next;
      so_valid_reg <= so_valid_next;
      done_reg     <= done_next;
`ifdef PISO_PARITY_EN
      par_reg      <= par_next;
`endif
    end
  end

  // so/so_valid/done are precomputed here so the registered outputs carry the
  // bit that corresponds to the counter value of the following cycle.
  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    sr_next       = sr_reg;
    so_next       = 1'b0;
    so_valid_next = 1'b0;
    done_next     = 1'b0;
`ifdef PISO_PARITY_EN
    par_next      = par_reg;
`endif
    if (accept) begin
      state_next    = SHIFT;
      cnt_next      = '0;
      sr_next       = {ord[WIDTH-2:0], 1'b0};
      so_next       = ord[WIDTH-1];
      so_valid_next = 1'b1;
`ifdef PISO_PARITY_EN
      par_next      = ^din;
`endif
    end else if (state_reg == SHIFT) begin
      if (last_bit) begin
        state_next = IDLE;
        cnt_next   = '0;
      end else begin
        cnt_next      = cnt_reg + CW'(1);
        sr_next       = {sr_reg[WIDTH-2:0], 1'b0};
        so_next       = sr_reg[WIDTH-1];
        so_valid_next = 1'b1;
        done_next     = (cnt_reg == CW'(FRAME_LEN - 2));
`ifdef PISO_PARITY_EN
        if (cnt_reg == CW'(WIDTH - 1)) begin
          so_next = par_reg;
        end
`endif
      end
    end
  end

  assign so       = so_reg;
  assign so_valid = so_valid_reg;
  assign done     = done_reg;
  assign busy     = (state_reg == SHIFT);

endmodule
